sd_spi_master: RTL and testbench

//  CPU-side SPI master for the SD card path: shifts one byte out on sd_sdi while sampling sd_sdo, SPI mode 0, MSB first.

---
 rtl/sd_spi_pkg.sv | 22 ++
 rtl/sd_spi_if.sv | 24 ++
 rtl/sd_spi_clkdiv.sv | 30 +++
 rtl/sd_spi_master.sv | 161 ++++++++++++++++
 tb/tb_sd_spi_master.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_spi_pkg.sv
// sd_spi_pkg: shared types and constants for the SD card SPI master.
// Optional feature macro used by the top: SD_SPI_ACT_LED_EN.
package sd_spi_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SHIFT_LO = 2'd1,
      SHIFT_HI = 2'd2,
      FINISH   = 2'd3
   } state_t;

   localparam int unsigned SLOW_DIV_DFLT = 31;
   localparam int unsigned FAST_DIV_DFLT = 0;

   // Width of a counter that must reach value d (at least one bit).
   function automatic int unsigned div_width(input int unsigned d);
      return (d < 1) ? 1 : $clog2(d + 1);
   endfunction

   localparam int unsigned DIV_W = div_width(SLOW_DIV_DFLT);

endpackage

// File: rtl/sd_spi_if.sv
// sd_spi_if: byte-level CPU-side handshake of the SD SPI master.
// The "master" modport is the requesting I/O port logic, "slave" is the SPI engine.
interface sd_spi_if;

   logic [7:0] tx_data;
   logic       tx_start;
   logic       fast;
   logic       cs_set;
   logic       cs_val;
   logic [7:0] rx_data;
   logic       busy;
   logic       done;

   modport master (
      output tx_data, tx_start, fast, cs_set, cs_val,
      input  rx_data, busy, done
   );

   modport slave (
      input  tx_data, tx_start, fast, cs_set, cs_val,
      output rx_data, busy, done
   );

endinterface

// File: rtl/sd_spi_clkdiv.sv
// sd_spi_clkdiv: sd_sck phase timer. Counts 0..div while enabled and emits
// a one-cycle phase_end tick on the last cycle of each half-period.
import sd_spi_pkg::*;

module sd_spi_clkdiv #(
   parameter int unsigned W = DIV_W
) (
   input  logic         clk_sys,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] div,
   output logic         phase_end
);

   logic [W-1:0] cnt;

   // Phase counter: held at zero when idle or restarted, wraps after div.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clr || !en || (cnt == div))
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   assign phase_end = en && (cnt == div);

endmodule

// File: rtl/sd_spi_master.sv
// sd_spi_master: SPI mode 0, MSB-first byte shifter toward the emulated SD card.
// Optional activity LED stretcher enabled by defining SD_SPI_ACT_LED_EN.
import sd_spi_pkg::*;

module sd_spi_master #(
   parameter int unsigned SLOW_DIV = SLOW_DIV_DFLT,
   parameter int unsigned FAST_DIV = FAST_DIV_DFLT,
   parameter int unsigned LED_HOLD = 2500000
) (
   input  logic        clk_sys,
   input  logic        rst_n,
   sd_spi_if.slave     host,
   output logic        sd_cs,
   output logic        sd_sck,
   output logic        sd_sdi,
   input  logic        sd_sdo,
   output logic        act_led
);

   localparam int unsigned DW = div_width((SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV);

   state_t         state, state_nxt;
   logic           load, rise, fall, last;
   logic           phase_end;
   logic [DW-1:0]  div_r;
   logic [6:0]     tx_sr;
   logic [7:0]     rx_sr;
   logic [2:0]     bit_cnt;
   logic           cs_pend, cs_pend_vld;
   logic           busy, done;

   assign busy         = (state == SHIFT_LO) || (state == SHIFT_HI);
   assign done         = (state == FINISH);
   assign host.busy    = busy;
   assign host.done    = done;

   sd_spi_clkdiv #(.W(DW)) u_clkdiv (
      .clk_sys   (clk_sys),
      .rst_n     (rst_n),
      .clr       (load),
      .en        (busy),
      .div       (div_r),
      .phase_end (phase_end)
   );

   // State register.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state and datapath strobes; the done cycle accepts a new start.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      rise      = 1'b0;
      fall      = 1'b0;
      last      = 1'b0;
      unique case (state)
         IDLE, FINISH: begin
            state_nxt = IDLE;
            if (host.tx_start) begin
               load      = 1'b1;
               state_nxt = SHIFT_LO;
            end
         end
         SHIFT_LO: if (phase_end) begin
            rise      = 1'b1;
            state_nxt = SHIFT_HI;
         end
         SHIFT_HI: if (phase_end) begin
            fall = 1'b1;
            if (bit_cnt == 3'd0) begin
               last      = 1'b1;
               state_nxt = FINISH;
            end else begin
               state_nxt = SHIFT_LO;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Shift datapath: sck edges, MOSI shifting, MISO sampling, result capture.
   // rx_data is captured on entry to FINISH so it is valid alongside done.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         sd_sck       <= 1'b0;
         sd_sdi       <= 1'b1;
         tx_sr        <= '1;
         rx_sr        <= '1;
         bit_cnt      <= '0;
         div_r        <= '0;
         host.rx_data <= 8'hFF;
      end else begin
         if (load) begin
            tx_sr   <= host.tx_data[6:0];
            sd_sdi  <= host.tx_data[7];
            bit_cnt <= 3'd7;
            div_r   <= host.fast ? DW'(FAST_DIV) : DW'(SLOW_DIV);
         end
         if (rise) begin
            sd_sck <= 1'b1;
            rx_sr  <= {rx_sr[6:0], sd_sdo};
         end
         if (fall) begin
            sd_sck <= 1'b0;
            if (last) begin
               sd_sdi       <= 1'b1;
               host.rx_data <= rx_sr;
            end else begin
               bit_cnt <= bit_cnt - 1'b1;
               sd_sdi  <= tx_sr[6];
               tx_sr   <= {tx_sr[5:0], 1'b1};
            end
         end
      end
   end

   // Chip select: direct load when not busy, deferred to the done cycle otherwise.
   // A strobe in the done cycle itself overrides the pending value.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         sd_cs       <= 1'b1;
         cs_pend     <= 1'b1;
         cs_pend_vld <= 1'b0;
      end else if (busy) begin
         if (host.cs_set) begin
            cs_pend     <= host.cs_val;
            cs_pend_vld <= 1'b1;
         end
      end else begin
         if (done && cs_pend_vld) begin
            sd_cs       <= cs_pend;
            cs_pend_vld <= 1'b0;
         end
         if (host.cs_set)
            sd_cs <= host.cs_val;
      end
   end

`ifdef SD_SPI_ACT_LED_EN
   localparam int unsigned LW = div_width(LED_HOLD);
   logic [LW-1:0] led_cnt;

   // Activity stretch: reloads at each done, then counts down to zero.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n)
         led_cnt <= '0;
      else if (done)
         led_cnt <= LW'(LED_HOLD);
      else if (led_cnt != '0)
         led_cnt <= led_cnt - 1'b1;
   end

   assign act_led = busy || done || (led_cnt != '0);
`else
   assign act_led = 1'b0;
`endif

endmodule

// File: tb/tb_sd_spi_master.sv
// tb_sd_spi_master: directed self-checking bench for sd_spi_master
// (SLOW_DIV=31, FAST_DIV=0, LED_HOLD=100).
module tb_sd_spi_master;

   logic       clk_sys = 1'b0;
   logic       rst_n   = 1'b0;
   logic       sd_cs, sd_sck, sd_sdi, sd_sdo, act_led;
   logic [7:0] card_sr = 8'hFF;
   logic [7:0] sdi_log = 8'h00;
   int         rises   = 0;
   int         dones   = 0;
   int         n_chk   = 0;
   int         n_fail  = 0;

   sd_spi_if bus ();

   sd_spi_master #(.SLOW_DIV(31), .FAST_DIV(0), .LED_HOLD(100)) dut (
      .clk_sys (clk_sys),
      .rst_n   (rst_n),
      .host    (bus.slave),
      .sd_cs   (sd_cs),
      .sd_sck  (sd_sck),
      .sd_sdi  (sd_sdi),
      .sd_sdo  (sd_sdo),
      .act_led (act_led)
   );

   always #5 clk_sys = ~clk_sys;

   // Card responder: MSB presented before the first rise, next bit after each fall.
   assign sd_sdo = card_sr[7];
   always @(negedge sd_sck) card_sr <= {card_sr[6:0], 1'b1};

   // Log MOSI at every sck rise and count rises / done cycles.
   always @(posedge sd_sck) begin
      sdi_log = {sdi_log[6:0], sd_sdi};
      rises++;
   end
   always @(posedge clk_sys) if (bus.done) dones++;

   // Drives a 1-cycle start; returns at the negedge of cycle N+1 (k=1).
   task automatic start_xfer(input logic [7:0] tx, input logic f, input logic [7:0] card);
      card_sr        = card;
      bus.tx_data    = tx;
      bus.fast       = f;
      bus.tx_start   = 1'b1;
      @(negedge clk_sys);
      bus.tx_start   = 1'b0;
   endtask

   // Advances negedges until done is seen or maxk is reached.
   task automatic wait_done(input int k0, input int maxk, output int k);
      k = k0;
      while (!bus.done && k < maxk) begin
         @(negedge clk_sys);
         k++;
      end
   endtask

   task automatic test_reset;
      bus.tx_data = 8'h00; bus.tx_start = 1'b0; bus.fast = 1'b0;
      bus.cs_set  = 1'b0;  bus.cs_val   = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(negedge clk_sys);
      rst_n = 1'b1;
      @(negedge clk_sys);
      n_chk++;
      if ({sd_cs, sd_sck, sd_sdi, bus.busy, bus.done, act_led} !== 6'b101000) begin
         n_fail++;
         $display("FAIL reset_pins: got cs/sck/sdi/busy/done/led=%b required 101000",
                  {sd_cs, sd_sck, sd_sdi, bus.busy, bus.done, act_led});
      end
      n_chk++;
      if (bus.rx_data !== 8'hFF) begin
         n_fail++;
         $display("FAIL reset_rx: got %h required ff", bus.rx_data);
      end
   endtask

   task automatic test_slow;
      int k, r0;
      r0 = rises;
      start_xfer(8'hA5, 1'b0, 8'h3C);
      n_chk++;
      if ({bus.busy, sd_sdi} !== 2'b11) begin
         n_fail++;
         $display("FAIL slow_start: got busy/sdi=%b required 11", {bus.busy, sd_sdi});
      end
      repeat (31) @(negedge clk_sys);   // k=32: still the first low phase
      n_chk++;
      if (sd_sck !== 1'b0) begin
         n_fail++;
         $display("FAIL slow_sck_lo: got %b required 0", sd_sck);
      end
      @(negedge clk_sys);               // k=33: first rise
      n_chk++;
      if (sd_sck !== 1'b1) begin
         n_fail++;
         $display("FAIL slow_sck_hi: got %b required 1", sd_sck);
      end
      wait_done(33, 700, k);
      n_chk++;
      if (k !== 513) begin
         n_fail++;
         $display("FAIL slow_latency: got %0d required 513", k);
      end
      n_chk++;
      if (bus.rx_data !== 8'h3C || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL slow_rx: got rx=%h busy=%b required rx=3c busy=0", bus.rx_data, bus.busy);
      end
      n_chk++;
      if (sdi_log !== 8'hA5 || rises - r0 !== 8) begin
         n_fail++;
         $display("FAIL slow_mosi: got bits=%h rises=%0d required a5 and 8", sdi_log, rises - r0);
      end
      @(negedge clk_sys);
      n_chk++;
      if ({bus.done, sd_sdi} !== 2'b01) begin
         n_fail++;
         $display("FAIL slow_after: got done/sdi=%b required 01", {bus.done, sd_sdi});
      end
   endtask

   task automatic test_fast;
      int k;
      logic [2:0] sck_seq;
      start_xfer(8'hFF, 1'b1, 8'h00);
      sck_seq[2] = sd_sck;
      @(negedge clk_sys); sck_seq[1] = sd_sck;
      @(negedge clk_sys); sck_seq[0] = sd_sck;
      n_chk++;
      if (sck_seq !== 3'b010) begin
         n_fail++;
         $display("FAIL fast_sck: got %b required 010", sck_seq);
      end
      wait_done(3, 40, k);
      n_chk++;
      if (k !== 17) begin
         n_fail++;
         $display("FAIL fast_latency: got %0d required 17", k);
      end
      n_chk++;
      if (bus.rx_data !== 8'h00 || sdi_log !== 8'hFF) begin
         n_fail++;
         $display("FAIL fast_data: got rx=%h bits=%h required 00 ff", bus.rx_data, sdi_log);
      end
      @(negedge clk_sys);
   endtask

   task automatic test_ignore_busy;
      int k, r0, d0;
      r0 = rises;
      start_xfer(8'h5A, 1'b1, 8'hC3);
      repeat (4) @(negedge clk_sys);
      bus.tx_data = 8'h00; bus.fast = 1'b0; bus.tx_start = 1'b1;
      @(negedge clk_sys);
      bus.tx_start = 1'b0;
      wait_done(6, 60, k);
      n_chk++;
      if (k !== 17) begin
         n_fail++;
         $display("FAIL ignore_latency: got %0d required 17", k);
      end
      n_chk++;
      if (bus.rx_data !== 8'hC3 || sdi_log !== 8'h5A || rises - r0 !== 8) begin
         n_fail++;
         $display("FAIL ignore_data: got rx=%h bits=%h rises=%0d required c3 5a 8",
                  bus.rx_data, sdi_log, rises - r0);
      end
      d0 = dones;
      repeat (40) @(negedge clk_sys);
      n_chk++;
      if (dones - d0 !== 1 || bus.busy !== 1'b0 || rises - r0 !== 8) begin
         n_fail++;
         $display("FAIL ignore_queue: got extra done=%0d busy=%b rises=%0d required 1 0 8",
                  dones - d0, bus.busy, rises - r0);
      end
   endtask

   task automatic test_cs_pending;
      int k;
      int bad;
      bad = 0;
      start_xfer(8'h33, 1'b1, 8'h99);
      repeat (6) @(negedge clk_sys);    // k=7
      bus.cs_val = 1'b0; bus.cs_set = 1'b1;
      @(negedge clk_sys);
      bus.cs_set = 1'b0;
      k = 8;
      while (!bus.done && k < 40) begin
         if (sd_cs !== 1'b1) bad++;
         @(negedge clk_sys);
         k++;
      end
      n_chk++;
      if (bad !== 0 || sd_cs !== 1'b1 || k !== 17) begin
         n_fail++;
         $display("FAIL cs_hold: got early changes=%0d cs=%b done_k=%0d required 0 1 17", bad, sd_cs, k);
      end
      @(negedge clk_sys);
      n_chk++;
      if (sd_cs !== 1'b0) begin
         n_fail++;
         $display("FAIL cs_apply: got %b required 0", sd_cs);
      end
   endtask

   task automatic test_cs_idle;
      int k;
      bus.cs_val = 1'b1; bus.cs_set = 1'b1;
      start_xfer(8'h01, 1'b1, 8'hFF);
      bus.cs_set = 1'b0;
      n_chk++;
      if ({sd_cs, bus.busy} !== 2'b11) begin
         n_fail++;
         $display("FAIL cs_with_start: got cs/busy=%b required 11", {sd_cs, bus.busy});
      end
      wait_done(1, 40, k);
      @(negedge clk_sys);
      bus.cs_val = 1'b0; bus.cs_set = 1'b1;
      @(negedge clk_sys);
      bus.cs_set = 1'b0;
      n_chk++;
      if (sd_cs !== 1'b0) begin
         n_fail++;
         $display("FAIL cs_idle: got %b required 0", sd_cs);
      end
   endtask

   task automatic test_back_to_back;
      int k;
      start_xfer(8'h81, 1'b1, 8'h7E);
      wait_done(1, 40, k);
      n_chk++;
      if (k !== 17 || bus.rx_data !== 8'h7E) begin
         n_fail++;
         $display("FAIL b2b_first: got k=%0d rx=%h required 17 7e", k, bus.rx_data);
      end
      start_xfer(8'h18, 1'b1, 8'h24);   // issued during the done cycle
      n_chk++;
      if ({bus.busy, sd_sdi} !== 2'b10) begin
         n_fail++;
         $display("FAIL b2b_accept: got busy/sdi=%b required 10", {bus.busy, sd_sdi});
      end
      wait_done(1, 40, k);
      n_chk++;
      if (k !== 17 || bus.rx_data !== 8'h24 || sdi_log !== 8'h18) begin
         n_fail++;
         $display("FAIL b2b_second: got k=%0d rx=%h bits=%h required 17 24 18", k, bus.rx_data, sdi_log);
      end
      @(negedge clk_sys);
   endtask

   task automatic test_led;
      int k;
`ifdef SD_SPI_ACT_LED_EN
      start_xfer(8'h11, 1'b1, 8'h22);
      n_chk++;
      if (act_led !== 1'b1) begin
         n_fail++;
         $display("FAIL led_busy: got %b required 1", act_led);
      end
      wait_done(1, 40, k);
      repeat (100) @(negedge clk_sys);
      n_chk++;
      if (act_led !== 1'b1) begin
         n_fail++;
         $display("FAIL led_hold: got %b required 1", act_led);
      end
      @(negedge clk_sys);
      n_chk++;
      if (act_led !== 1'b0) begin
         n_fail++;
         $display("FAIL led_off: got %b required 0", act_led);
      end
`else
      start_xfer(8'h11, 1'b1, 8'h22);
      n_chk++;
      if (act_led !== 1'b0) begin
         n_fail++;
         $display("FAIL led_tied: got %b required 0", act_led);
      end
      wait_done(1, 40, k);
      @(negedge clk_sys);
`endif
   endtask

   task automatic test_reset_mid;
      int d0;
      start_xfer(8'hA5, 1'b0, 8'hFF);
      repeat (99) @(negedge clk_sys);   // k=100: second high phase, sdi = bit 6 = 0
      n_chk++;
      if ({sd_sck, sd_sdi, sd_cs, bus.busy} !== 4'b1001) begin
         n_fail++;
         $display("FAIL rst_pre: got sck/sdi/cs/busy=%b required 1001",
                  {sd_sck, sd_sdi, sd_cs, bus.busy});
      end
      rst_n = 1'b0;
      #1;
      n_chk++;
      if ({sd_sck, sd_sdi, sd_cs, bus.busy} !== 4'b0110) begin
         n_fail++;
         $display("FAIL rst_async: got sck/sdi/cs/busy=%b required 0110",
                  {sd_sck, sd_sdi, sd_cs, bus.busy});
      end
      @(negedge clk_sys);
      rst_n = 1'b1;
      d0 = dones;
      repeat (600) @(negedge clk_sys);
      n_chk++;
      if (dones !== d0 || bus.rx_data !== 8'hFF || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_after: got dones=%0d rx=%h busy=%b required %0d ff 0",
                  dones, bus.rx_data, bus.busy, d0);
      end
   endtask

   initial begin
      test_reset();
      test_slow();
      test_fast();
      test_ignore_busy();
      test_cs_pending();
      test_cs_idle();
      test_back_to_back();
      test_led();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
